// File: rtl/mmio_write_router.sv
// mmio_write_router: routes core stores into per-channel write FIFOs by address
// region. Each FIFO drains to its peripheral over a show-ahead valid/ready port.
// Stores that hit no region are dropped, and the router counts them and keeps
// the address of the most recent one.
module mmio_write_router #(
  parameter int unsigned          NUM_CH      = 2,
  parameter int unsigned          ADDR_W      = 32,
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          FIFO_DEPTH  = 4,
  parameter logic [ADDR_W-1:0]    BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned          REGION_LOG2 = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_we,
  output logic                       in_stall,
  output logic [NUM_CH-1:0]          out_valid,
  output logic [NUM_CH*ADDR_W-1:0]   out_addr,
  output logic [NUM_CH*DATA_W-1:0]   out_data,
  input  logic [NUM_CH-1:0]          out_ready,
  output logic [15:0]                miss_count,
  output logic [ADDR_W-1:0]          miss_addr
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] off_hi;
  logic              match;
  logic [CH_W-1:0]   ch;
  logic [NUM_CH-1:0] ch_sel;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;

  // Address decode: region index is the offset from the base, shifted down by the region size
  always_comb begin
    off    = in_addr - BASE_ADDR;
    off_hi = off >> REGION_LOG2;
    match  = (in_addr >= BASE_ADDR) && (off_hi < ADDR_W'(NUM_CH));
    ch     = off_hi[CH_W-1:0];
  end

  // One-hot channel select; the stall depends only on the address and the registered fill levels
  always_comb begin
    ch_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (match && (ch == CH_W'(k))) begin
        ch_sel[k] = 1'b1;
      end
    end
    push     = {NUM_CH{rst && in_we}} & ch_sel & ~full;
    pop      = {NUM_CH{rst}} & out_valid & out_ready;
    in_stall = rst && in_we && |(ch_sel & full);
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] head;

    assign full[k]      = (count == CNT_W'(FIFO_DEPTH));
    assign out_valid[k] = (count != '0);
    assign head         = mem[rd_ptr];
    assign out_addr[k*ADDR_W +: ADDR_W] = head[ENTRY_W-1:DATA_W];
    assign out_data[k*DATA_W +: DATA_W] = head[DATA_W-1:0];

    // Storage write only; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
      if (push[k]) begin
        mem[wr_ptr] <= {in_addr, in_data};
      end
    end

    // Pointer and fill-level bookkeeping; a simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk) begin
      if (!rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[k]) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop[k]) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push[k], pop[k]})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Unmatched stores: saturating counter plus last offending address
  always_ff @(posedge clk) begin
    if (!rst) begin
      miss_count <= '0;
      miss_addr  <= '0;
    end else if (in_we && !match) begin
      miss_addr <= in_addr;
      if (miss_count != 16'hFFFF) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mmio_write_router.sv
// tb_mmio_write_router: directed vectors for the default 2-channel router, with
// hand-written sequences for stall-on-full, wrap-around, simultaneous push/pop,
// mid-operation reset and miss counter saturation.
module tb_mmio_write_router;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic        in_we;
  logic        in_stall;
  logic [1:0]  out_valid;
  logic [63:0] out_addr;
  logic [63:0] out_data;
  logic [1:0]  out_ready;
  logic [15:0] miss_count;
  logic [31:0] miss_addr;

  int vec_count = 0;
  int miscompares = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  ready;
    logic        exp_stall;
    logic [1:0]  exp_valid;
    logic [15:0] exp_miss;
    logic [31:0] exp_a0;
    logic [31:0] exp_d0;
    logic [31:0] exp_a1;
    logic [31:0] exp_d1;
  } vec_t;

  vec_t vecs[$];

  mmio_write_router dut (
    .clk        (clk),
    .rst        (rst),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .in_we      (in_we),
    .in_stall   (in_stall),
    .out_valid  (out_valid),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .miss_count (miss_count),
    .miss_addr  (miss_addr)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    in_we     = v.we;
    in_addr   = v.addr;
    in_data   = v.data;
    out_ready = v.ready;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int issued;
    int drained;
    int mcount;
    logic exp_stall;
    logic do_pop;
    logic [63:0] q[$];

    // Directed vectors: one cycle each, stall checked before the edge, state after it
    vecs.push_back('{1'b1, 32'h0001_0004, 32'hDEAD_BEEF, 2'b00, 1'b0, 2'b01, 16'd0,
                     32'h0001_0004, 32'hDEAD_BEEF, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h0002_0008, 32'h1234_5678, 2'b00, 1'b0, 2'b11, 16'd0,
                     32'h0001_0004, 32'hDEAD_BEEF, 32'h0002_0008, 32'h1234_5678});
    vecs.push_back('{1'b0, 32'h0, 32'h0, 2'b11, 1'b0, 2'b00, 16'd0, 32'h0, 32'h0, 32'h0, 32'h0});
    for (int i = 0; i < 4; i++) begin
      vecs.push_back('{1'b1, 32'h0001_0010 + 32'(4*i), 32'hA0A0_0000 + 32'(i), 2'b00, 1'b0, 2'b01,
                       16'd0, 32'h0001_0010, 32'hA0A0_0000, 32'h0, 32'h0});
    end
    vecs.push_back('{1'b1, 32'h0001_0020, 32'hA0A0_0004, 2'b00, 1'b1, 2'b01, 16'd0,
                     32'h0001_0010, 32'hA0A0_0000, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h0001_0020, 32'hA0A0_0004, 2'b01, 1'b1, 2'b01, 16'd0,
                     32'h0001_0014, 32'hA0A0_0001, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h0001_0020, 32'hA0A0_0004, 2'b00, 1'b0, 2'b01, 16'd0,
                     32'h0001_0014, 32'hA0A0_0001, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 32'h0, 32'h0, 2'b01, 1'b0, 2'b01, 16'd0, 32'h0001_0018, 32'hA0A0_0002, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 32'h0, 32'h0, 2'b01, 1'b0, 2'b01, 16'd0, 32'h0001_001C, 32'hA0A0_0003, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 32'h0, 32'h0, 2'b01, 1'b0, 2'b01, 16'd0, 32'h0001_0020, 32'hA0A0_0004, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 32'h0, 32'h0, 2'b01, 1'b0, 2'b00, 16'd0, 32'h0, 32'h0, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 32'h0, 32'h0, 2'b11, 1'b0, 2'b00, 16'd0, 32'h0, 32'h0, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_FFFC, 32'h1111_1111, 2'b00, 1'b0, 2'b00, 16'd1, 32'h0, 32'h0, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 32'h0003_0000, 32'h2222_2222, 2'b00, 1'b0, 2'b00, 16'd2, 32'h0, 32'h0, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 32'hFFFF_0000, 32'h3333_3333, 2'b00, 1'b0, 2'b00, 16'd3, 32'h0, 32'h0, 32'h0, 32'h0});

    // Reset held for two edges with a store pending
    rst       = 1'b0;
    in_we     = 1'b1;
    in_addr   = 32'h0001_0004;
    in_data   = 32'hDEAD_BEEF;
    out_ready = 2'b00;
    tick();
    checkOutput("reset_stall", 64'(in_stall), 64'd0);
    tick();
    checkOutput("reset_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_miss_count", 64'(miss_count), 64'd0);
    checkOutput("reset_miss_addr", 64'(miss_addr), 64'd0);
    in_we = 1'b0;
    rst   = 1'b1;
    tick();
    checkOutput("post_reset_valid", 64'(out_valid), 64'd0);

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_stall", i), 64'(in_stall), 64'(vecs[i].exp_stall));
      tick();
      checkOutput($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
      checkOutput($sformatf("v%0d_miss", i), 64'(miss_count), 64'(vecs[i].exp_miss));
      if (vecs[i].exp_valid[0]) begin
        checkOutput($sformatf("v%0d_head0", i), {out_addr[31:0], out_data[31:0]},
                    {vecs[i].exp_a0, vecs[i].exp_d0});
      end
      if (vecs[i].exp_valid[1]) begin
        checkOutput($sformatf("v%0d_head1", i), {out_addr[63:32], out_data[63:32]},
                    {vecs[i].exp_a1, vecs[i].exp_d1});
      end
    end
    checkOutput("miss_addr", 64'(miss_addr), 64'hFFFF_0000);

    // Simultaneous push and pop on a channel holding two entries
    in_we = 1'b1; out_ready = 2'b00;
    in_addr = 32'h0001_0100; in_data = 32'h5A5A_0000; tick();
    in_addr = 32'h0001_0104; in_data = 32'h5A5A_0001; tick();
    in_addr = 32'h0001_0108; in_data = 32'h5A5A_0002; out_ready = 2'b01;
    #1;
    checkOutput("pp_stall", 64'(in_stall), 64'd0);
    tick();
    checkOutput("pp_head_a", {out_addr[31:0], out_data[31:0]}, {32'h0001_0104, 32'h5A5A_0001});
    in_we = 1'b0;
    tick();
    checkOutput("pp_valid_b", 64'(out_valid), 64'b01);
    checkOutput("pp_head_b", {out_addr[31:0], out_data[31:0]}, {32'h0001_0108, 32'h5A5A_0002});
    tick();
    checkOutput("pp_empty", 64'(out_valid), 64'd0);

    // Wrap-around on channel 1 with ready toggling every cycle
    issued = 0; drained = 0; mcount = 0;
    for (int cyc = 0; cyc < 100 && drained < 10; cyc++) begin
      in_we     = (issued < 10);
      in_addr   = 32'h0002_0000 + 32'(4*issued);
      in_data   = 32'hC0DE_0000 + 32'(issued);
      out_ready = {logic'(cyc % 2), 1'b0};
      #1;
      exp_stall = in_we && (mcount == 4);
      do_pop    = (mcount != 0) && out_ready[1];
      checkOutput("wrap_stall", 64'(in_stall), 64'(exp_stall));
      checkOutput("wrap_valid", 64'(out_valid[1]), 64'(mcount != 0));
      if (do_pop) begin
        checkOutput("wrap_head", {out_addr[63:32], out_data[63:32]}, q[0]);
      end
      tick();
      if (in_we && !exp_stall) begin
        q.push_back({in_addr, in_data});
        issued++;
        mcount++;
      end
      if (do_pop) begin
        void'(q.pop_front());
        drained++;
        mcount--;
      end
    end
    checkOutput("wrap_drained", 64'(drained), 64'd10);
    out_ready = 2'b00;

    // Reset mid-operation discards posted writes and clears miss state
    in_we = 1'b1; in_addr = 32'h0001_0000; in_data = 32'h7777_0000; tick();
    in_addr = 32'h0002_0000; tick();
    in_addr = 32'h0000_0000; tick();
    checkOutput("mid_valid_before", 64'(out_valid), 64'b11);
    in_addr = 32'h0001_0004;
    rst = 1'b0;
    #1;
    checkOutput("mid_reset_stall", 64'(in_stall), 64'd0);
    tick();
    rst = 1'b1; in_we = 1'b0;
    checkOutput("mid_reset_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_reset_miss", 64'(miss_count), 64'd0);
    checkOutput("mid_reset_miss_addr", 64'(miss_addr), 64'd0);

    // Miss counter saturation
    in_we = 1'b1; in_addr = 32'h0000_0040;
    repeat (70000) tick();
    in_we = 1'b0;
    checkOutput("miss_saturate", 64'(miss_count), 64'hFFFF);
    checkOutput("miss_sat_addr", 64'(miss_addr), 64'h0000_0040);
    checkOutput("miss_sat_valid", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/mmio_write_router.md
# mmio_write_router

Parametrised write-path router between the core's store port and memory-mapped write-only peripherals such as video memory. It decodes each store address into one of NUM_CH contiguous address regions and posts the write into that channel's FIFO. Each FIFO drains to its peripheral over a valid/ready handshake. Stores outside every region are dropped and counted.

## Interface
Parameters:
- NUM_CH, 2: number of output channels; must be 1–8.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- FIFO_DEPTH, 4: entries per channel; must be a power of two, at least 2.
- BASE_ADDR, 32'h0001_0000: start of the channel 0 region.
- REGION_LOG2, 16: log2 of the region size in bytes. Channel k covers [BASE_ADDR + k·2^REGION_LOG2, BASE_ADDR + (k+1)·2^REGION_LOG2 − 1]. BASE_ADDR must be aligned to 2^REGION_LOG2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- in_addr  in  ADDR_W  store address from the core.
- in_data  in  DATA_W  store data.
- in_we  in  1  store request.
- in_stall  out  1  combinational; the core must hold the store while this is high.
- out_valid  out  NUM_CH  per-channel FIFO non-empty.
- out_addr  out  NUM_CH·ADDR_W  head address of each channel's FIFO (absolute); channel k occupies bits [k·ADDR_W +: ADDR_W].
- out_data  out  NUM_CH·DATA_W  head data of each channel's FIFO, packed the same way.
- out_ready  in  NUM_CH  per-channel peripheral accept.
- miss_count  out  16  number of unmatched stores; saturates at 16'hFFFF.
- miss_addr  out  ADDR_W  address of the most recent unmatched store.

## Operation
- Decode: off = in_addr − BASE_ADDR, computed unsigned at ADDR_W width. If in_addr ≥ BASE_ADDR and off[ADDR_W−1:REGION_LOG2] < NUM_CH, then ch = off >> REGION_LOG2 and the store matches. Otherwise it is a miss.
- Accept: in_we, a match, and full[ch] == 0. On the edge, {in_addr, in_data} is written at wr_ptr[ch]; wr_ptr[ch] and count[ch] are updated.
- Stall: in_stall = rst && in_we && match && full[ch]. Nothing is accepted while stalled, and the core re-presents the identical store.
- Miss: in_we without a match is never stalled. On the edge, miss_count increments (held at 16'hFFFF once reached) and miss_addr ← in_addr.
- Drain, per channel independently: out_valid[k] = (count[k] != 0). Outputs are show-ahead: out_addr/out_data present the entry at rd_ptr[k] combinationally. A pop occurs when out_valid[k] && out_ready[k]. out_ready while empty has no effect.
- Count update per channel: push only → +1; pop only → −1; push and pop together → unchanged, with both pointers advancing.
- Full: count == FIFO_DEPTH. full is evaluated from the registered count, so a push into a full FIFO is refused even if the same channel pops on that edge. That store stalls one cycle and is accepted on the next edge.
- Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. count is log2(FIFO_DEPTH)+1 bits wide.
- Ordering: FIFO order within a channel. No ordering guarantee holds across channels.

## Timing
- Reset (rst == 0 at a rising edge) clears all pointers, counts, miss_count to 0 and miss_addr to 0, so out_valid = 0 from the next cycle. While rst == 0: in_stall = 0, no push, pop or miss update occurs, and FIFO contents are discarded.
- Reset mid-operation discards all posted but undrained writes. No partial handshakes survive reset.
- Push-to-valid latency is 1 cycle. A store accepted at edge N has out_valid high during cycle N+1, and the peripheral can pop it at edge N+1 at the earliest.
- Throughput is one push and one pop per channel per cycle. A channel with ready held high and a steady store stream never fills.
- in_stall depends combinationally on in_addr, in_we and the registered count; it has no path from out_ready.
- out_addr and out_data are stable while out_valid is high and out_ready is low.

## Test plan
- Reset, default parameters: hold rst = 0 for 2 edges with in_we = 1 → out_valid = 2'b00, miss_count = 0, in_stall = 0, no entries posted.
- Single route: store 0x0001_0004 / 0xDEAD_BEEF, then 0x0002_0008 / 0x1234_5678 → ch0 head = {0x0001_0004, 0xDEAD_BEEF}, ch1 head = {0x0002_0008, 0x1234_5678}; each out_valid rises 1 cycle after its accept.
- Fill and stall: out_ready = 0, 5 stores to ch0 → first 4 accepted, in_stall = 1 on the 5th. Raise out_ready[0] for one edge → 5th store still stalled that cycle, accepted the next. Drain order matches issue order.
- Wrap-around: 10 stores to ch1 with out_ready[1] toggling every cycle → all 10 drained in order, count never exceeds 4, pointers wrap twice.
- Miss handling: stores to 0x0000_FFFC, 0x0003_0000 and 0xFFFF_0000 → no stall, nothing posted, miss_count = 3, miss_addr = 0xFFFF_0000. Force 70000 misses → miss_count = 16'hFFFF.
- Simultaneous push/pop on a non-full FIFO holding 2 entries → count stays 2, data order is preserved.
